// File: rtl/mmm_pkg.sv
// Shared types for the branch-prediction front end: machine word width,
// the branch resolution record and the resolution-queue depth.
package mmm_pkg;

    localparam int XLEN        = 32;
    localparam int RES_Q_DEPTH = 4;

    // One resolved branch as reported by an execute-stage branch unit.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic            taken;
    } resolution_t;

endpackage

// File: rtl/res_queue.sv
// Branch-resolution queue: accepts up to two in-order resolutions per cycle
// from the branch units and replays them one per cycle to the gshare
// predictor. The predictor therefore updates its history and PHT strictly in
// program order.
module res_queue
    import mmm_pkg::*;
#(
    parameter int DEPTH = RES_Q_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  resolution_t                res0_i,
    input  resolution_t                res1_i,
    output logic                       ready_o,
    output resolution_t                res_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // Payload storage; validity is implied by the occupancy count.
    logic [XLEN-1:0] r_pc    [DEPTH];
    logic            r_taken [DEPTH];

    ptr_t r_wr_ptr;
    ptr_t r_rd_ptr;
    cnt_t r_count;

    logic w_ready;
    logic w_push0;
    logic w_push1;
    logic w_pop;
    ptr_t w_wr_ptr1;
    cnt_t w_n_push;

    // Two free slots are needed so a dual push can never overflow.
    assign w_ready = (DEPTH - int'(r_count)) >= 2;

    // Flush wins over both push and pop.
    assign w_push0 = w_ready && !flush_i && res0_i.valid;
    assign w_push1 = w_ready && !flush_i && res1_i.valid;
    assign w_pop   = (r_count != '0) && !flush_i;

    // res1 lands right after res0 when both push, otherwise at wr_ptr (no hole).
    assign w_wr_ptr1 = r_wr_ptr + ptr_t'(w_push0);
    assign w_n_push  = cnt_t'(w_push0) + cnt_t'(w_push1);

    // Write accepted resolutions into the circular buffer.
    // NOTE: the payload array has no reset; an entry is only ever read while
    // the count says it is occupied, so its power-up contents never matter.
    always_ff @(posedge clk_i) begin
        if (w_push0) begin
            r_pc[r_wr_ptr]    <= res0_i.pc;
            r_taken[r_wr_ptr] <= res0_i.taken;
        end
        if (w_push1) begin
            r_pc[w_wr_ptr1]    <= res1_i.pc;
            r_taken[w_wr_ptr1] <= res1_i.taken;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + ptr_t'(w_n_push);
            r_rd_ptr <= r_rd_ptr + ptr_t'(w_pop);
            r_count  <= r_count + w_n_push - cnt_t'(w_pop);
        end
    end

    // Present the head entry; the predictor always consumes it this cycle.
    // NOTE: the output is defaulted to zero first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        res_o = '0;
        if (r_count != '0) begin
            res_o.valid = 1'b1;
            res_o.pc    = r_pc[r_rd_ptr];
            res_o.taken = r_taken[r_rd_ptr];
        end
    end

    assign ready_o = w_ready;
    assign count_o = r_count;

    // Producer must hold a younger resolution until the queue is ready.
    a_res1_protocol: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(res1_i.valid && !w_ready && !flush_i));

endmodule
